mips_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter for the Avalon memory-mapped bus used by `mips_cpu_bus`. Port 0 connects to the CPU bus master and port 1 to a secondary master (program loader / DMA / debug). Both share a single memory slave. The block grants the slave to one master per transaction, forwards the granted master's signals and stalls the other master through `waitrequest`.

---
 rtl/mips_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_mips_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_arbiter.sv
// rtl/mips_bus_arbiter.sv - two-master, one-slave Avalon-MM arbiter; MIPS_ARB_ROUND_ROBIN_EN selects round-robin ties
module mips_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_waitrequest,
    input  logic [DATA_W-1:0]     s_readdata,
    output logic [1:0]            grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;
    logic   last;
    logic   req0;
    logic   req1;
    logic   pick1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Tie-break: which port wins when the arbiter makes a decision this cycle.
`ifdef MIPS_ARB_ROUND_ROBIN_EN
    assign pick1 = req1 & (~req0 | ~last);
`else
    assign pick1 = req1 & ~req0;
`endif

    // Next owner: decide from IDLE, on completion, or drop to IDLE when the owner abandons.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req0 | req1) state_nx = pick1 ? OWN1 : OWN0;
            end
            OWN0: begin
                if (!req0)               state_nx = IDLE;
                else if (!s_waitrequest) state_nx = pick1 ? OWN1 : OWN0;
            end
            OWN1: begin
                if (!req1)               state_nx = IDLE;
                else if (!s_waitrequest) state_nx = pick1 ? OWN1 : OWN0;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, last-granted port and registered one-hot grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            last  <= 1'b1;
            grant <= 2'b00;
        end else begin
            state <= state_nx;
            grant <= {state_nx == OWN1, state_nx == OWN0};
            last  <= (state_nx == OWN1) ? 1'b1 :
                     (state_nx == OWN0) ? 1'b0 : last;
        end
    end

    // Forward the owner's signals to the slave and stall everyone else.
    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (state)
            OWN0: begin
                s_address      = m0_address;
                s_read         = m0_read;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest;
            end
            OWN1: begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest;
            end
            default: ;
        endcase
    end

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb/tb_mips_bus_arbiter.sv - self-checking bench for mips_bus_arbiter
module tb_mips_bus_arbiter;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, s_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [31:0] s_readdata;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;

    // Reference model: current owner (-1 none, 0, 1) and most recently granted port.
    int own;
    int lst;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(grant)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 0; s_readdata = '0;
    endtask

    task automatic go_idle();
        clear_inputs();
        tick();
        tick();
    endtask

    function automatic int arb_pick(bit r0, bit r1);
        if (r0 && r1) return RR ? ((lst == 1) ? 0 : 1) : 0;
        return r0 ? 0 : 1;
    endfunction

    task automatic test_reset();
        clear_inputs();
        reset = 0;
        m0_read = 1;
        m1_write = 1;
        tick();
        tick();
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant); end
        checks++; if (s_read !== 1'b0 || s_write !== 1'b0) begin errors++; $display("FAIL reset_strobes got %b%b exp 00", s_read, s_write); end
        checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait got %b%b exp 11", m0_waitrequest, m1_waitrequest); end
        clear_inputs();
        tick();
        reset = 1;
        tick();
    endtask

    task automatic test_single_read();
        m0_read = 1; m0_address = 32'hBFC00000; m0_byteenable = 4'hF;
        s_readdata = 32'h24020005; s_waitrequest = 0;
        @(negedge clk);
        checks++; if (m0_waitrequest !== 1'b1 || grant !== 2'b00 || s_read !== 1'b0) begin errors++; $display("FAIL read_arb_cycle got w=%b g=%b r=%b exp w=1 g=00 r=0", m0_waitrequest, grant, s_read); end
        tick();
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL read_grant got %b exp 01", grant); end
        checks++; if (s_read !== 1'b1 || s_address !== 32'hBFC00000) begin errors++; $display("FAIL read_fwd got r=%b a=%h exp r=1 a=bfc00000", s_read, s_address); end
        checks++; if (m0_waitrequest !== 1'b0 || m0_readdata !== 32'h24020005) begin errors++; $display("FAIL read_data got w=%b d=%h exp w=0 d=24020005", m0_waitrequest, m0_readdata); end
        tick();
        m0_read = 0;
        @(negedge clk);
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL read_drop got %b exp 0", s_read); end
        tick();
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL read_release got %b exp 00", grant); end
        go_idle();
    endtask

    task automatic test_slave_stall();
        int wcount = 0;
        m1_write = 1; m1_address = 32'h1000; m1_writedata = 32'hDEADBEEF; m1_byteenable = 4'hF;
        s_waitrequest = 1;
        @(negedge clk);
        checks++; if (s_write !== 1'b0 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL stall_arb got sw=%b w1=%b exp sw=0 w1=1", s_write, m1_waitrequest); end
        tick();
        for (int i = 0; i < 4; i++) begin
            s_waitrequest = (i < 3);
            @(negedge clk);
            if (s_write === 1'b1) wcount++;
            checks++; if (s_writedata !== 32'hDEADBEEF || s_address !== 32'h1000 || s_byteenable !== 4'hF) begin errors++; $display("FAIL stall_data got a=%h d=%h be=%h exp a=1000 d=deadbeef be=f", s_address, s_writedata, s_byteenable); end
            checks++; if (m1_waitrequest !== (i < 3) || m0_waitrequest !== 1'b1 || grant !== 2'b10) begin errors++; $display("FAIL stall_wait got w1=%b w0=%b g=%b exp w1=%b w0=1 g=10", m1_waitrequest, m0_waitrequest, grant, (i < 3)); end
            tick();
        end
        checks++; if (wcount !== 4) begin errors++; $display("FAIL stall_write_cycles got %0d exp 4", wcount); end
        go_idle();
    endtask

    task automatic test_tie_policy();
        int seq[$];
        int c0 = 0;
        int c1 = 0;
        int cyc = 0;
        int exp_port;
        m0_read = 1; m0_address = 32'h100;
        m1_read = 1; m1_address = 32'h200;
        s_waitrequest = 0;
        while ((c0 < 4 || c1 < 4) && cyc < 60) begin
            @(negedge clk);
            if (m0_read && m0_waitrequest === 1'b0) begin seq.push_back(0); c0++; end
            if (m1_read && m1_waitrequest === 1'b0) begin seq.push_back(1); c1++; end
            tick();
            if (c0 >= 4) m0_read = 0;
            if (c1 >= 4) m1_read = 0;
            cyc++;
        end
        checks++; if (seq.size() !== 8) begin errors++; $display("FAIL tie_count got %0d exp 8", seq.size()); end
        for (int i = 0; i < 8 && i < seq.size(); i++) begin
            exp_port = RR ? (i % 2) : (i / 4);
            checks++; if (seq[i] !== exp_port) begin errors++; $display("FAIL tie_order[%0d] got %0d exp %0d", i, seq[i], exp_port); end
        end
        go_idle();
    endtask

    task automatic test_abandon();
        m0_read = 1; m0_address = 32'h40; s_waitrequest = 1;
        tick();
        m1_read = 1; m1_address = 32'h80;
        @(negedge clk);
        checks++; if (s_read !== 1'b1 || grant !== 2'b01) begin errors++; $display("FAIL abandon_own got r=%b g=%b exp r=1 g=01", s_read, grant); end
        #2 m0_read = 0;
        #1;
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL abandon_drop got %b exp 0", s_read); end
        tick();
        @(negedge clk);
        checks++; if (grant !== 2'b00 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL abandon_idle got g=%b w1=%b exp g=00 w1=1", grant, m1_waitrequest); end
        tick();
        @(negedge clk);
        checks++; if (grant !== 2'b10 || s_address !== 32'h80 || s_read !== 1'b1) begin errors++; $display("FAIL abandon_m1 got g=%b a=%h r=%b exp g=10 a=80 r=1", grant, s_address, s_read); end
        go_idle();
    endtask

    task automatic test_reset_mid();
        m1_write = 1; m1_address = 32'h300; m1_writedata = 32'h55; s_waitrequest = 1;
        tick();
        @(negedge clk);
        checks++; if (s_write !== 1'b1 || grant !== 2'b10) begin errors++; $display("FAIL rstmid_own got w=%b g=%b exp w=1 g=10", s_write, grant); end
        #2 reset = 0;
        #1;
        checks++; if (s_write !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL rstmid_async got w=%b g=%b exp w=0 g=00", s_write, grant); end
        clear_inputs();
        tick();
        reset = 1;
        m0_read = 1; m0_address = 32'h10;
        @(negedge clk);
        checks++; if (grant !== 2'b00 || m0_waitrequest !== 1'b1) begin errors++; $display("FAIL rstmid_arb got g=%b w0=%b exp g=00 w0=1", grant, m0_waitrequest); end
        tick();
        @(negedge clk);
        checks++; if (grant !== 2'b01 || m0_waitrequest !== 1'b0) begin errors++; $display("FAIL rstmid_grant got g=%b w0=%b exp g=01 w0=0", grant, m0_waitrequest); end
        go_idle();
    endtask

    task automatic test_random();
        logic [31:0] ea, ed;
        logic [3:0]  ebe;
        logic        er, ew, ew0, ew1;
        logic [1:0]  eg;
        bit          r0, r1, rq;
        clear_inputs();
        reset = 0;
        tick();
        reset = 1;
        own = -1;
        lst = 1;
        for (int c = 0; c < 300; c++) begin
            m0_read = ($urandom_range(0, 2) != 0); m0_write = ($urandom_range(0, 4) == 0);
            m1_read = ($urandom_range(0, 2) == 0); m1_write = ($urandom_range(0, 2) == 0);
            m0_address = $urandom; m0_writedata = $urandom; m0_byteenable = 4'($urandom);
            m1_address = $urandom; m1_writedata = $urandom; m1_byteenable = 4'($urandom);
            s_waitrequest = ($urandom_range(0, 2) == 0); s_readdata = $urandom;
            @(negedge clk);
            ea = '0; ed = '0; ebe = '0; er = 0; ew = 0; ew0 = 1; ew1 = 1; eg = 2'b00;
            if (own == 0) begin
                ea = m0_address; ed = m0_writedata; ebe = m0_byteenable; er = m0_read; ew = m0_write;
                ew0 = s_waitrequest; eg = 2'b01;
            end else if (own == 1) begin
                ea = m1_address; ed = m1_writedata; ebe = m1_byteenable; er = m1_read; ew = m1_write;
                ew1 = s_waitrequest; eg = 2'b10;
            end
            checks++; if (grant !== eg) begin errors++; $display("FAIL rnd_grant c=%0d got %b exp %b", c, grant, eg); end
            checks++; if (s_read !== er || s_write !== ew) begin errors++; $display("FAIL rnd_strobe c=%0d got %b%b exp %b%b", c, s_read, s_write, er, ew); end
            checks++; if (s_address !== ea) begin errors++; $display("FAIL rnd_addr c=%0d got %h exp %h", c, s_address, ea); end
            checks++; if (s_writedata !== ed || s_byteenable !== ebe) begin errors++; $display("FAIL rnd_wdata c=%0d got %h/%h exp %h/%h", c, s_writedata, s_byteenable, ed, ebe); end
            checks++; if (m0_waitrequest !== ew0 || m1_waitrequest !== ew1) begin errors++; $display("FAIL rnd_wait c=%0d got %b%b exp %b%b", c, m0_waitrequest, m1_waitrequest, ew0, ew1); end
            checks++; if (m0_readdata !== s_readdata || m1_readdata !== s_readdata) begin errors++; $display("FAIL rnd_rdata c=%0d got %h/%h exp %h", c, m0_readdata, m1_readdata, s_readdata); end
            r0 = m0_read | m0_write;
            r1 = m1_read | m1_write;
            if (own == -1) begin
                if (r0 || r1) own = arb_pick(r0, r1);
            end else begin
                rq = (own == 0) ? r0 : r1;
                if (!rq) own = -1;
                else if (!s_waitrequest) own = arb_pick(r0, r1);
            end
            if (own != -1) lst = own;
            tick();
        end
        go_idle();
    endtask

    initial begin
        clear_inputs();
        reset = 0;
        test_reset();
        test_single_read();
        test_slave_stall();
        test_tie_policy();
        test_abandon();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
